// File: rtl/serial_carry_adder.sv
// Bit-serial adder: computes a + b + c_in one bit per clock, LSB first,
// through a single registered full-adder slice behind a start/busy/done handshake.
module serial_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-2:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;

    assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    // New bit enters at the top; after WIDTH shifts bit 0 of the result sits at the bottom.
    assign w_res_next = {w_s, r_res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_res   <= w_res_next[WIDTH-1:1];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == S_SHIFT);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule

// File: tb/tb_serial_carry_adder.sv
// Self-checking bench for serial_carry_adder: directed cases, reset cases,
// exhaustive sweep and random operations against an arithmetic reference.
module tb_serial_carry_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [W:0]  prev;

    serial_carry_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain (W+1)-bit unsigned addition.
    function automatic logic [W:0] ref_add(input int unsigned av, input int unsigned bv,
                                           input int unsigned cv);
        return (W+1)'(av + bv + cv);
    endfunction

    // One operation; glitch >= 0 raises start for one cycle during SHIFT.
    task automatic run_op(input int unsigned av, input int unsigned bv,
                          input int unsigned cv, input int glitch);
        logic [W:0] exp;
        exp = ref_add(av, bv, cv);
        @(negedge clk);
        start = 1'b1;
        a     = W'(av);
        b     = W'(bv);
        c_in  = cv[0];
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = (i == glitch);
            if (i == glitch) begin
                a = '0;
                b = '0;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            c_in = 1'($urandom);
            check("shift", 32'({busy, done, c_out, sum}), 32'({1'b1, 1'b0, prev}));
        end
        @(negedge clk);
        start = 1'b0;
        check("done", 32'({busy, done, c_out, sum}), 32'({1'b0, 1'b1, exp}));
        prev = exp;
        @(negedge clk);
        check("idle", 32'({busy, done, c_out, sum}), 32'({1'b0, 1'b0, exp}));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        prev  = '0;
        repeat (2) @(negedge clk);
        check("reset", 32'({busy, done, c_out, sum}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", 32'({busy, done, c_out, sum}), 32'd0);

        run_op(3, 5, 0, -1);
        run_op(15, 1, 0, -1);
        run_op(15, 15, 1, -1);
        run_op(6, 3, 1, 1);
        repeat (3) begin
            @(negedge clk);
            check("no_extra_done", 32'({busy, done}), 32'd0);
        end

        // Continuous start: one result every W+1 cycles.
        @(negedge clk);
        start = 1'b1;
        a     = W'(9);
        b     = W'(4);
        c_in  = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                check("cont_busy", 32'({busy, done}), 32'b10);
            end
            @(negedge clk);
            check("cont_done", 32'({busy, done, c_out, sum}), 32'({1'b0, 1'b1, ref_add(9, 4, 0)}));
        end
        start = 1'b0;
        prev  = ref_add(9, 4, 0);
        @(negedge clk);
        check("cont_idle", 32'({busy, done}), 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        start = 1'b1;
        a     = W'(12);
        b     = W'(12);
        c_in  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_async", 32'({busy, done, c_out, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev = '0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            check("rst_quiet", 32'({busy, done, c_out, sum}), 32'd0);
        end

        // Reset and start together: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = W'(7);
        b     = W'(7);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start", 32'({busy, done, c_out, sum}), 32'd0);

        // Exhaustive sweep.
        for (int unsigned x = 0; x < (1 << W); x++)
            for (int unsigned y = 0; y < (1 << W); y++)
                for (int unsigned c = 0; c < 2; c++)
                    run_op(x, y, c, -1);

        // Random operations with random ignored start pulses.
        repeat (40) begin
            run_op($urandom_range((1 << W) - 1), $urandom_range((1 << W) - 1),
                   $urandom_range(1), int'($urandom_range(W)) - 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
